player_motion_fsm: RTL and testbench

Parametrised next-generation player controller for the Dino runner: one FSM owning game-flow state (restart, run, jump, duck, game over) plus integrated fixed-point jump physics with configurable launch velocity, normal and fast-fall gravity, landing jump-buffer and game-over restart hold-off. Sits between the debounced button inputs / tick generator and the renderer and collision checker; all outputs are registered.

---
 rtl/player_motion_fsm_pkg.sv | 29 ++
 rtl/player_motion_fsm_jump_physics.sv | 84 ++++++++
 rtl/player_motion_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_player_motion_fsm.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/player_motion_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : player_motion_fsm_pkg
//  Description : Shared definitions for the Dino runner player controller:
//                FSM state encoding, game_tick bit indices, counter sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package player_motion_fsm_pkg;

   // Encoding is shared with the renderer, so the values are fixed.
   typedef enum logic [2:0] {
      ST_RESTART   = 3'd0,
      ST_JUMPING   = 3'd1,
      ST_RUNNING   = 3'd2,
      ST_DUCKING   = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_e;

   // Bit positions inside the game_tick strobe bus.
   localparam int c_tick_frame = 0;
   localparam int c_tick_phys  = 1;

   // Width of a down-counter that must hold max_val (at least 1 bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/player_motion_fsm_jump_physics.sv
`default_nettype none
// ============================================================================
//  Module      : player_jump_physics
//  Description : Fixed-point jump integrator. Holds height and signed
//                velocity, applies normal or fast-fall gravity with
//                saturation, clamps at the ceiling and reports landing.
//  Revision    : 1.0 - initial release
// ============================================================================
module player_jump_physics #(
   parameter int POS_W       = 8,
   parameter int VEL_W       = 6,
   parameter int JUMP_VEL    = 12,
   parameter int GRAVITY     = 1,
   parameter int FAST_FALL_G = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear_i,
   input  logic             launch_i,
   input  logic             step_i,
   input  logic             fast_i,
   output logic [POS_W-1:0] pos_o,
   output logic             land_o
);

   // Two guard bits: one for overflow above the ceiling, one for sign.
   localparam int c_sum_w = POS_W + 2;

   localparam logic signed [VEL_W-1:0] c_jump_vel = VEL_W'(JUMP_VEL);
   localparam logic signed [VEL_W:0]   c_g_norm   = (VEL_W+1)'(GRAVITY);
   localparam logic signed [VEL_W:0]   c_g_fast   = (VEL_W+1)'(FAST_FALL_G);
   // Most negative velocity, sign-extended by one bit.
   localparam logic signed [VEL_W:0]   c_vel_min  = {2'b11, {(VEL_W-1){1'b0}}};

   logic        [POS_W-1:0]   pos_q;
   logic signed [VEL_W-1:0]   vel_q;
   logic signed [c_sum_w-1:0] w_sum;
   logic signed [VEL_W:0]     w_grav;
   logic signed [VEL_W:0]     w_vel_dec;
   logic signed [VEL_W-1:0]   w_vel_sat;
   logic                      w_sum_le0;
   logic                      w_vel_le0;
   logic                      w_ceil;

   // Candidate next height/velocity and the land/ceiling conditions.
   always_comb begin
      w_sum     = $signed({2'b00, pos_q}) + c_sum_w'(vel_q);
      w_sum_le0 = w_sum[c_sum_w-1] | (w_sum == '0);
      w_vel_le0 = vel_q[VEL_W-1] | (vel_q == '0);
      land_o    = w_sum_le0 & w_vel_le0;
      // Non-negative but with the overflow guard bit set: above max height.
      w_ceil    = ~w_sum[c_sum_w-1] & (w_sum[c_sum_w-2:POS_W] != '0);
      w_grav    = fast_i ? c_g_fast : c_g_norm;
      w_vel_dec = (VEL_W+1)'(vel_q) - w_grav;
      w_vel_sat = (w_vel_dec < c_vel_min) ? c_vel_min[VEL_W-1:0]
                                          : w_vel_dec[VEL_W-1:0];
   end

   // Position/velocity registers: clear > launch > physics step > hold.
   always_ff @(posedge clk) begin
      if (!reset_n || clear_i) begin
         pos_q <= '0;
         vel_q <= '0;
      end else if (launch_i) begin
         pos_q <= '0;
         vel_q <= c_jump_vel;
      end else if (step_i) begin
         if (land_o) begin
            pos_q <= '0;
            vel_q <= '0;
         end else if (w_ceil) begin
            pos_q <= '1;
            vel_q <= '0;
         end else begin
            pos_q <= w_sum[POS_W-1:0];
            vel_q <= w_vel_sat;
         end
      end
   end

   assign pos_o = pos_q;

endmodule
`default_nettype wire

// File: rtl/player_motion_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : player_motion_fsm
//  Description : Dino runner player controller. Game-flow FSM with jump
//                buffer and game-over hold-off counters; jump physics are
//                delegated to player_jump_physics. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module player_motion_fsm
   import player_motion_fsm_pkg::*;
#(
   parameter int POS_W       = 8,
   parameter int VEL_W       = 6,
   parameter int JUMP_VEL    = 12,
   parameter int GRAVITY     = 1,
   parameter int FAST_FALL_G = 3,
   parameter int JUMP_BUF    = 4,
   parameter int HOLDOFF     = 30
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       game_tick,
   input  logic             button_up,
   input  logic             button_down,
   input  logic             crash,
   output logic [POS_W-1:0] player_position,
   output logic             game_start_pulse,
   output logic             game_over_pulse,
   output logic             jump_pulse,
   output logic             jumping,
   output logic             ducking,
   output logic [2:0]       state
);

   localparam int c_buf_w  = cnt_width(JUMP_BUF);
   localparam int c_ho_w   = cnt_width(HOLDOFF);
   localparam bit c_buf_en = (JUMP_BUF != 0);

   state_e              state_q;
   state_e              w_state_d;
   logic                start_q;
   logic                over_q;
   logic                jump_q;
   logic                jumping_q;
   logic                ducking_q;
   logic [c_buf_w-1:0]  buf_q;
   logic [c_ho_w-1:0]   holdoff_q;

   logic                w_frame;
   logic                w_phys;
   logic                w_land;
   logic                w_launch;
   logic                w_step;
   logic                w_clear;
   logic                w_start;
   logic                w_over;
   logic                w_relaunch;
   logic [c_ho_w-1:0]   w_ho_dec;

   assign w_frame = game_tick[c_tick_frame];
   assign w_phys  = game_tick[c_tick_phys];

   // Saturating hold-off decrement; button_up is accepted on the frame
   // tick that brings the count to zero.
   assign w_ho_dec = (holdoff_q == '0) ? '0 : holdoff_q - c_ho_w'(1);

   // A press on the landing frame tick counts as buffered too.
   assign w_relaunch = c_buf_en && ((buf_q != '0) || (w_frame && button_up));

   // Next-state and physics control; frame-tick decisions take precedence.
   always_comb begin
      w_state_d = state_q;
      w_launch  = 1'b0;
      w_step    = 1'b0;
      w_clear   = 1'b0;
      w_start   = 1'b0;
      w_over    = 1'b0;
      case (state_q)
         ST_RESTART: begin
            if (w_frame && button_up) begin
               w_state_d = ST_JUMPING;
               w_start   = 1'b1;
               w_launch  = 1'b1;
            end
         end
         ST_RUNNING: begin
            if (w_frame) begin
               if (crash) begin
                  w_state_d = ST_GAME_OVER;
                  w_over    = 1'b1;
               end else if (button_up) begin
                  w_state_d = ST_JUMPING;
                  w_launch  = 1'b1;
               end else if (button_down) begin
                  w_state_d = ST_DUCKING;
               end
            end
         end
         ST_DUCKING: begin
            if (w_frame) begin
               if (crash) begin
                  w_state_d = ST_GAME_OVER;
                  w_over    = 1'b1;
               end else if (!button_down) begin
                  w_state_d = ST_RUNNING;
               end
            end
         end
         ST_JUMPING: begin
            if (w_frame && crash) begin
               // Crash beats landing; position freezes where it is.
               w_state_d = ST_GAME_OVER;
               w_over    = 1'b1;
            end else if (w_phys && w_land) begin
               if (w_relaunch) begin
                  w_launch = 1'b1;
               end else begin
                  w_state_d = ST_RUNNING;
                  w_step    = 1'b1;
               end
            end else if (w_phys) begin
               w_step = 1'b1;
            end
         end
         ST_GAME_OVER: begin
            if (w_frame && button_up && (w_ho_dec == '0)) begin
               w_state_d = ST_RUNNING;
               w_start   = 1'b1;
               w_clear   = 1'b1;
            end
         end
         default: begin
            w_state_d = ST_RESTART;
            w_clear   = 1'b1;
         end
      endcase
   end

   // Game-flow FSM with registered outputs, jump buffer and hold-off.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_RESTART;
         start_q   <= 1'b0;
         over_q    <= 1'b0;
         jump_q    <= 1'b0;
         jumping_q <= 1'b0;
         ducking_q <= 1'b0;
         buf_q     <= '0;
         holdoff_q <= '0;
      end else begin
         state_q   <= w_state_d;
         start_q   <= w_start;
         over_q    <= w_over;
         jump_q    <= w_launch;
         jumping_q <= (w_state_d == ST_JUMPING);
         ducking_q <= (w_state_d == ST_DUCKING);

         // Buffer lives only within one airborne phase.
         if ((w_state_d != ST_JUMPING) || w_launch) begin
            buf_q <= '0;
         end else if (w_frame && button_up) begin
            buf_q <= c_buf_w'(JUMP_BUF);
         end else if (w_frame && (buf_q != '0)) begin
            buf_q <= buf_q - c_buf_w'(1);
         end

         if (w_state_d != ST_GAME_OVER) begin
            holdoff_q <= '0;
         end else if (state_q != ST_GAME_OVER) begin
            holdoff_q <= c_ho_w'(HOLDOFF);
         end else if (w_frame) begin
            holdoff_q <= w_ho_dec;
         end
      end
   end

   player_jump_physics #(
      .POS_W       (POS_W),
      .VEL_W       (VEL_W),
      .JUMP_VEL    (JUMP_VEL),
      .GRAVITY     (GRAVITY),
      .FAST_FALL_G (FAST_FALL_G)
   ) u_physics (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_i  (w_clear),
      .launch_i (w_launch),
      .step_i   (w_step),
      .fast_i   (button_down),
      .pos_o    (player_position),
      .land_o   (w_land)
   );

   assign game_start_pulse = start_q;
   assign game_over_pulse  = over_q;
   assign jump_pulse       = jump_q;
   assign jumping          = jumping_q;
   assign ducking          = ducking_q;
   assign state            = state_q;

endmodule
`default_nettype wire

// File: tb/tb_player_motion_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_motion_fsm
//  Description : Self-checking bench for player_motion_fsm with default
//                parameters: vector table plus directed corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_player_motion_fsm;

   localparam logic [2:0] S_RESTART = 3'd0;
   localparam logic [2:0] S_JUMPING = 3'd1;
   localparam logic [2:0] S_RUNNING = 3'd2;
   localparam logic [2:0] S_DUCKING = 3'd3;
   localparam logic [2:0] S_GOVER   = 3'd4;

   typedef struct {
      logic [1:0] tick;
      logic       up;
      logic       down;
      logic       crash;
      logic       chk;
      logic [2:0] st;
      logic [7:0] pos;
      logic       s;
      logic       o;
      logic       j;
   } vec_t;

   logic       clk;
   logic       reset_n;
   logic [1:0] game_tick;
   logic       button_up;
   logic       button_down;
   logic       crash;
   logic [7:0] player_position;
   logic       game_start_pulse;
   logic       game_over_pulse;
   logic       jump_pulse;
   logic       jumping;
   logic       ducking;
   logic [2:0] state;

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];

   // Height after physics tick k (index k-1), JUMP_VEL 12, gravity 1.
   int c_traj[25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
                      77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};

   player_motion_fsm dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .game_tick        (game_tick),
      .button_up        (button_up),
      .button_down      (button_down),
      .crash            (crash),
      .player_position  (player_position),
      .game_start_pulse (game_start_pulse),
      .game_over_pulse  (game_over_pulse),
      .jump_pulse       (jump_pulse),
      .jumping          (jumping),
      .ducking          (ducking),
      .state            (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [1:0] t, input logic u,
                               input logic d, input logic c, input logic chk,
                               input logic [2:0] st, input int p,
                               input logic s, input logic o, input logic j);
      vec_t v;
      v.tick = t;  v.up = u;  v.down = d;  v.crash = c;  v.chk = chk;
      v.st = st;   v.pos = p[7:0];  v.s = s;  v.o = o;  v.j = j;
      return v;
   endfunction

   // Drive one strobe cycle, drop the strobe, compare one cycle later.
   task automatic apply(input vec_t v, input string tag, input int idx);
      logic [15:0] act;
      logic [15:0] exp;
      @(negedge clk);
      game_tick   = v.tick;
      button_up   = v.up;
      button_down = v.down;
      crash       = v.crash;
      @(negedge clk);
      game_tick = 2'b00;
      if (v.chk) begin
         checks++;
         act = {state, player_position, game_start_pulse, game_over_pulse,
                jump_pulse, jumping, ducking};
         exp = {v.st, v.pos, v.s, v.o, v.j,
                (v.st == S_JUMPING), (v.st == S_DUCKING)};
         if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got st=%0d pos=%0d start/over/jump=%b%b%b jumping=%b ducking=%b, expected st=%0d pos=%0d start/over/jump=%b%b%b jumping=%b ducking=%b",
                     tag, idx, state, player_position, game_start_pulse,
                     game_over_pulse, jump_pulse, jumping, ducking,
                     v.st, v.pos, v.s, v.o, v.j,
                     (v.st == S_JUMPING), (v.st == S_DUCKING));
         end
      end
   endtask

   // Physics-only flight ticks from..to, checked against the trajectory.
   task automatic fly(input int from, input int to, input logic [1:0] t,
                      input string tag);
      for (int k = from; k <= to; k++) begin
         apply(mk(t, 1'b0, 1'b0, 1'b0, 1'b1,
                  (k == 25) ? S_RUNNING : S_JUMPING, c_traj[k-1],
                  1'b0, 1'b0, 1'b0), tag, k);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      game_tick   = 2'b00;
      button_up   = 1'b0;
      button_down = 1'b0;
      crash       = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // ---------------- vector table: full default jump, ducking ----------
      tbl.push_back(mk(2'b00, 0, 0, 0, 1, S_RESTART, 0, 0, 0, 0));
      tbl.push_back(mk(2'b01, 1, 0, 0, 1, S_JUMPING, 0, 1, 0, 1));
      for (int k = 1; k <= 25; k++)
         tbl.push_back(mk(2'b10, 0, 0, 0, 1,
                          (k == 25) ? S_RUNNING : S_JUMPING, c_traj[k-1],
                          0, 0, 0));
      tbl.push_back(mk(2'b01, 0, 1, 0, 1, S_DUCKING, 0, 0, 0, 0));
      tbl.push_back(mk(2'b01, 1, 1, 0, 1, S_DUCKING, 0, 0, 0, 0));
      tbl.push_back(mk(2'b10, 0, 1, 0, 1, S_DUCKING, 0, 0, 0, 0));
      tbl.push_back(mk(2'b01, 0, 0, 0, 1, S_RUNNING, 0, 0, 0, 0));
      foreach (tbl[i]) apply(tbl[i], "table", i);

      // ---------------- fast fall from the peak ----------------------------
      apply(mk(2'b01, 1, 0, 0, 1, S_JUMPING, 0, 0, 0, 1), "ff_launch", 0);
      fly(1, 12, 2'b10, "ff_rise");
      begin
         int ff_pos[8] = '{78, 75, 69, 60, 48, 33, 15, 0};
         for (int k = 0; k < 8; k++)
            apply(mk(2'b10, 0, 1, 0, 1, (k == 7) ? S_RUNNING : S_JUMPING,
                     ff_pos[k], 0, 0, 0), "ff_fall", k + 13);
      end
      apply(mk(2'b01, 0, 1, 0, 1, S_DUCKING, 0, 0, 0, 0), "ff_duck", 0);
      apply(mk(2'b01, 0, 0, 0, 1, S_RUNNING, 0, 0, 0, 0), "ff_run", 0);

      // ---------------- jump buffer: 2 ticks early relaunches --------------
      apply(mk(2'b01, 1, 0, 0, 1, S_JUMPING, 0, 0, 0, 1), "buf_launch", 0);
      fly(1, 22, 2'b10, "buf_a");
      apply(mk(2'b11, 1, 0, 0, 1, S_JUMPING, 23, 0, 0, 0), "buf_press", 23);
      apply(mk(2'b11, 0, 0, 0, 1, S_JUMPING, 12, 0, 0, 0), "buf_a", 24);
      apply(mk(2'b11, 0, 0, 0, 1, S_JUMPING, 0, 0, 0, 1), "buf_relaunch", 25);
      // ---------------- 5 ticks early expires before landing ---------------
      fly(1, 19, 2'b10, "buf_b");
      apply(mk(2'b11, 1, 0, 0, 1, S_JUMPING, 50, 0, 0, 0), "buf_press5", 20);
      fly(21, 24, 2'b11, "buf_b");
      apply(mk(2'b11, 0, 0, 0, 1, S_RUNNING, 0, 0, 0, 0), "buf_expired", 25);

      // ---------------- crash on landing tick, hold-off --------------------
      apply(mk(2'b01, 1, 0, 0, 1, S_JUMPING, 0, 0, 0, 1), "crash_launch", 0);
      fly(1, 24, 2'b10, "crash_fly");
      apply(mk(2'b11, 0, 0, 1, 1, S_GOVER, 12, 0, 1, 0), "crash_land", 25);
      apply(mk(2'b10, 0, 0, 0, 1, S_GOVER, 12, 0, 0, 0), "crash_frozen", 0);
      for (int k = 1; k <= 28; k++)
         apply(mk(2'b01, 0, 0, 0, 0, S_GOVER, 12, 0, 0, 0), "holdoff", k);
      apply(mk(2'b01, 1, 0, 0, 1, S_GOVER, 12, 0, 0, 0), "holdoff_29", 29);
      apply(mk(2'b01, 1, 0, 0, 1, S_RUNNING, 0, 1, 0, 0), "holdoff_30", 30);

      // ---------------- crash has priority over button_up in RUNNING -------
      apply(mk(2'b01, 1, 0, 1, 1, S_GOVER, 0, 0, 1, 0), "run_crash", 0);
      apply(mk(2'b01, 0, 0, 0, 1, S_GOVER, 0, 0, 0, 0), "run_crash_once", 0);

      // ---------------- reset, then reset mid-jump -------------------------
      reset_n = 1'b0;
      apply(mk(2'b00, 0, 0, 0, 1, S_RESTART, 0, 0, 0, 0), "reset", 0);
      reset_n = 1'b1;
      apply(mk(2'b01, 1, 0, 0, 1, S_JUMPING, 0, 1, 0, 1), "rst_launch", 0);
      fly(1, 3, 2'b10, "rst_fly");
      reset_n = 1'b0;
      apply(mk(2'b11, 1, 0, 0, 1, S_RESTART, 0, 0, 0, 0), "rst_midjump", 0);
      reset_n = 1'b1;
      apply(mk(2'b00, 0, 0, 0, 1, S_RESTART, 0, 0, 0, 0), "rst_after", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
